// File: rtl/lts_capture_mc.sv
// Multi-channel LTS capture: channel-0 moving-sum power trigger, capture of LTS_LEN
// beats of every channel into a buffer, then AXI-Stream drain with tlast and backpressure.
module lts_capture_mc #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned LTS_LEN     = 128,
  parameter int unsigned POW_WIN     = 16,
  parameter int unsigned ARM_TIMEOUT = 400
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic                             s_axis_tvalid,
  input  logic [N_CH*2*SAMPLE_W-1:0]       s_axis_tdata,
  output logic                             s_axis_tready,
  input  logic                             lts_sync_in,
  input  logic [SAMPLE_W+$clog2(POW_WIN):0] power_thresh_in,
  output logic                             m_axis_tvalid,
  output logic [N_CH*2*SAMPLE_W-1:0]       m_axis_tdata,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  output logic                             power_trig_out,
  output logic                             busy_out,
  output logic [15:0]                      pkt_cnt_out,
  output logic [15:0]                      drop_cnt_out
);

  localparam int unsigned BEAT_W = N_CH * 2 * SAMPLE_W;
  localparam int unsigned MAG_W  = SAMPLE_W + 1;
  localparam int unsigned SUM_W  = MAG_W + $clog2(POW_WIN);
  localparam int unsigned ADDR_W = $clog2(LTS_LEN);
  localparam int unsigned RD_W   = $clog2(LTS_LEN + 1);
  localparam int unsigned TMO_W  = $clog2(ARM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN,
    ST_HOLDOFF
  } state_t;

  state_t state, state_next;

  logic signed [MAG_W-1:0] i_ext, q_ext;
  logic [MAG_W-1:0]        abs_i, abs_q, mag;
  logic [MAG_W-1:0]        hist [POW_WIN];
  logic [SUM_W-1:0]        sum, sum_next;

  logic [ADDR_W-1:0] wr_ptr, wr_addr;
  logic [RD_W-1:0]   rd_ptr;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [BEAT_W-1:0] mem [LTS_LEN];

  logic beat, wr_en, wr_first, tmo_clr, tmo_inc, drop_sync, drop_abort, pkt_inc, rd_load;
  logic [16:0] drop_sum;

  assign s_axis_tready = 1'b1;
  assign beat          = s_axis_tvalid;

  // Channel-0 magnitude |I|+|Q|; one extra bit keeps |-2^(W-1)| exact
  assign i_ext    = {s_axis_tdata[2*SAMPLE_W-1], s_axis_tdata[2*SAMPLE_W-1:SAMPLE_W]};
  assign q_ext    = {s_axis_tdata[SAMPLE_W-1], s_axis_tdata[SAMPLE_W-1:0]};
  assign abs_i    = i_ext[MAG_W-1] ? -i_ext : i_ext;
  assign abs_q    = q_ext[MAG_W-1] ? -q_ext : q_ext;
  assign mag      = abs_i + abs_q;
  assign sum_next = sum + SUM_W'(mag) - SUM_W'(hist[POW_WIN-1]);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < int'(POW_WIN); i++) hist[i] <= '0;
      sum            <= '0;
      power_trig_out <= 1'b0;
    end else if (beat) begin
      hist[0] <= mag;
      for (int i = 1; i < int'(POW_WIN); i++) hist[i] <= hist[i-1];
      sum            <= sum_next;
      power_trig_out <= (sum_next >= power_thresh_in);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_next;
  end

  // Next state and datapath controls; sync takes priority over both ARMED exits
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_first   = 1'b0;
    tmo_clr    = 1'b0;
    tmo_inc    = 1'b0;
    drop_sync  = 1'b0;
    drop_abort = 1'b0;
    pkt_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (power_trig_out) begin
          state_next = ST_ARMED;
          tmo_clr    = 1'b1;
        end
      end
      ST_ARMED: begin
        if (beat && lts_sync_in) begin
          state_next = ST_CAPTURE;
          wr_en      = 1'b1;
          wr_first   = 1'b1;
        end else if (!power_trig_out) begin
          state_next = ST_IDLE;
        end else if (beat) begin
          if (tmo_cnt == TMO_W'(ARM_TIMEOUT - 1)) state_next = ST_HOLDOFF;
          else                                    tmo_inc    = 1'b1;
        end
      end
      ST_CAPTURE: begin
        drop_sync = beat && lts_sync_in;
        if (beat && wr_ptr == ADDR_W'(LTS_LEN - 1)) begin
          wr_en      = 1'b1;
          state_next = ST_DRAIN;
        end else if (!power_trig_out) begin
          drop_abort = 1'b1;
          state_next = ST_HOLDOFF;
        end else if (beat) begin
          wr_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        drop_sync = beat && lts_sync_in;
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          pkt_inc    = 1'b1;
          state_next = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (!power_trig_out) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign wr_addr = wr_first ? '0 : wr_ptr;
  assign rd_load = (state == ST_DRAIN) && (rd_ptr != RD_W'(LTS_LEN)) &&
                   (!m_axis_tvalid || m_axis_tready);

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= s_axis_tdata;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr  <= '0;
      tmo_cnt <= '0;
    end else begin
      if (wr_en)        wr_ptr  <= wr_addr + ADDR_W'(1);
      if (tmo_clr)      tmo_cnt <= '0;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Output register doubles as the buffer's registered read port
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (state != ST_DRAIN) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (rd_load) begin
      m_axis_tdata  <= mem[rd_ptr[ADDR_W-1:0]];
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= (rd_ptr == RD_W'(LTS_LEN - 1));
      rd_ptr        <= rd_ptr + RD_W'(1);
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end
  end

  assign drop_sum = 17'(drop_cnt_out) + 17'(drop_sync) + 17'(drop_abort);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pkt_cnt_out  <= '0;
      drop_cnt_out <= '0;
      busy_out     <= 1'b0;
    end else begin
      if (pkt_inc && pkt_cnt_out != 16'hFFFF) pkt_cnt_out <= pkt_cnt_out + 16'd1;
      drop_cnt_out <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      busy_out     <= (state_next == ST_CAPTURE) || (state_next == ST_DRAIN);
    end
  end

endmodule
